// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: allocates NUM_BUFS external-memory frame slots between a
// frame writer and a frame reader. Each slot is FREE, WRITING, READY or
// READING; the writer never takes the slot being read, and the reader always
// gets the newest completed frame. Slot ages come from a wrapping sequence tag.
module frame_buffer_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    NUM_BUFS   = 3,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
   parameter int                    SEQ_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           frame_bytes,
   input  logic                  wr_req,
   output logic                  wr_grant,
   output logic [ADDR_WIDTH-1:0] wr_base_addr,
   output logic [2:0]            wr_idx,
   input  logic                  wr_done,
   input  logic                  rd_req,
   output logic                  rd_grant,
   output logic [ADDR_WIDTH-1:0] rd_base_addr,
   output logic [SEQ_WIDTH-1:0]  rd_seq,
   input  logic                  rd_done,
   output logic [15:0]           drop_cnt,
   output logic [3:0]            ready_cnt
);

   typedef enum logic [1:0] {
      S_FREE    = 2'd0,
      S_WRITING = 2'd1,
      S_READY   = 2'd2,
      S_READING = 2'd3
   } slot_state_t;

   typedef enum logic [1:0] {W_IDLE, W_GRANT, W_ACTIVE} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACTIVE}  rd_state_t;

   localparam int PROD_W = ADDR_WIDTH + 35;

   // Slot table
   slot_state_t          slot_state_reg [NUM_BUFS];
   slot_state_t          slot_state_next[NUM_BUFS];
   logic [SEQ_WIDTH-1:0] slot_tag_reg   [NUM_BUFS];
   logic [SEQ_WIDTH-1:0] slot_tag_next  [NUM_BUFS];
   logic [SEQ_WIDTH-1:0] wr_seq_reg, wr_seq_next;

   // FSM state
   wr_state_t wr_state_reg, wr_state_next;
   rd_state_t rd_state_reg, rd_state_next;

   // Registered outputs and slot ownership
   logic                  wr_grant_reg;
   logic [ADDR_WIDTH-1:0] wr_base_addr_reg;
   logic [2:0]            wr_idx_reg;
   logic                  rd_grant_reg;
   logic [ADDR_WIDTH-1:0] rd_base_addr_reg;
   logic [SEQ_WIDTH-1:0]  rd_seq_reg;
   logic [2:0]            rd_slot_reg;
   logic [15:0]           drop_cnt_reg;
   logic [3:0]            ready_cnt_reg, ready_cnt_next;

   // Per-slot views of the pre-edge table
   logic [NUM_BUFS-1:0]  free_vec;
   logic [NUM_BUFS-1:0]  ready_vec;
   logic [SEQ_WIDTH-1:0] age [NUM_BUFS];

   // Arbitration results
   logic                 free_found;
   logic [2:0]           free_idx;
   logic                 rd_found;
   logic [2:0]           rd_pick;
   logic [SEQ_WIDTH-1:0] rd_pick_tag;
   logic [SEQ_WIDTH-1:0] best_new;
   logic                 old_found;
   logic [2:0]           old_pick;
   logic [SEQ_WIDTH-1:0] best_old;
   logic                 rd_take;
   logic                 wr_take;
   logic [2:0]           wr_pick;
   logic                 wr_drop;
   logic                 wr_commit;
   logic                 rd_release;

   // Slot base address, truncated to the address width
   function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [2:0]  idx,
                                                       input logic [31:0] stride);
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(idx) * PROD_W'(stride);
      return BASE_ADDR + prod[ADDR_WIDTH-1:0];
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BUFS; gi++) begin : g_slot_view
         assign free_vec[gi]  = (slot_state_reg[gi] == S_FREE);
         assign ready_vec[gi] = (slot_state_reg[gi] == S_READY);
         assign age[gi]       = wr_seq_reg - slot_tag_reg[gi];
      end
   endgenerate

   // Lowest-index FREE slot (scan downward so the lowest index wins)
   always_comb begin
      free_found = 1'b0;
      free_idx   = 3'd0;
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            free_found = 1'b1;
            free_idx   = 3'(i);
         end
      end
   end

   // Newest READY slot (smallest age) for the reader
   always_comb begin
      rd_found    = 1'b0;
      rd_pick     = 3'd0;
      rd_pick_tag = '0;
      best_new    = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (ready_vec[i] && (!rd_found || age[i] < best_new)) begin
            rd_found    = 1'b1;
            rd_pick     = 3'(i);
            rd_pick_tag = slot_tag_reg[i];
            best_new    = age[i];
         end
      end
   end

   assign rd_take = (rd_state_reg == R_WAIT) && rd_found;

   // Oldest READY slot for the writer's overwrite fallback, skipping any slot the reader takes this cycle
   always_comb begin
      old_found = 1'b0;
      old_pick  = 3'd0;
      best_old  = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (ready_vec[i] && !(rd_take && rd_pick == 3'(i)) &&
             (!old_found || age[i] > best_old)) begin
            old_found = 1'b1;
            old_pick  = 3'(i);
            best_old  = age[i];
         end
      end
   end

   assign wr_take    = (wr_state_reg == W_GRANT);
   assign wr_pick    = free_found ? free_idx : old_pick;
   assign wr_drop    = wr_take && !free_found && old_found;
   assign wr_commit  = (wr_state_reg == W_ACTIVE) && wr_done;
   assign rd_release = (rd_state_reg == R_ACTIVE) && rd_done;

   // Writer FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_state_reg <= W_IDLE;
      else        wr_state_reg <= wr_state_next;
   end

   // Writer FSM next state
   always_comb begin
      wr_state_next = wr_state_reg;
      case (wr_state_reg)
         W_IDLE:   if (wr_req) wr_state_next = W_GRANT;
         W_GRANT:  wr_state_next = W_ACTIVE;
         W_ACTIVE: if (wr_done) wr_state_next = W_IDLE;
         default:  wr_state_next = W_IDLE;
      endcase
   end

   // Reader FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_state_reg <= R_IDLE;
      else        rd_state_reg <= rd_state_next;
   end

   // Reader FSM next state
   always_comb begin
      rd_state_next = rd_state_reg;
      case (rd_state_reg)
         R_IDLE:   if (rd_req) rd_state_next = R_WAIT;
         R_WAIT:   if (rd_found) rd_state_next = R_ACTIVE;
         R_ACTIVE: if (rd_done) rd_state_next = R_IDLE;
         default:  rd_state_next = R_IDLE;
      endcase
   end

   // Slot table next state; all four events may land on the same edge on distinct slots
   always_comb begin
      wr_seq_next = wr_seq_reg;
      for (int i = 0; i < NUM_BUFS; i++) begin
         slot_state_next[i] = slot_state_reg[i];
         slot_tag_next[i]   = slot_tag_reg[i];
         if (wr_commit && wr_idx_reg == 3'(i)) begin
            slot_state_next[i] = S_READY;
            slot_tag_next[i]   = wr_seq_reg;
         end
         if (rd_release && rd_slot_reg == 3'(i)) slot_state_next[i] = S_FREE;
         if (rd_take && rd_pick == 3'(i))        slot_state_next[i] = S_READING;
         if (wr_take && wr_pick == 3'(i))        slot_state_next[i] = S_WRITING;
      end
      if (wr_commit) wr_seq_next = wr_seq_reg + 1'b1;
   end

   // Count READY slots in the post-edge table
   always_comb begin
      ready_cnt_next = 4'd0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (slot_state_next[i] == S_READY) ready_cnt_next = ready_cnt_next + 4'd1;
      end
   end

   // Slot table and sequence counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            slot_state_reg[i] <= S_FREE;
            slot_tag_reg[i]   <= '0;
         end
         wr_seq_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_BUFS; i++) begin
            slot_state_reg[i] <= slot_state_next[i];
            slot_tag_reg[i]   <= slot_tag_next[i];
         end
         wr_seq_reg <= wr_seq_next;
      end
   end

   // Grant pulses, granted addresses (held until the next grant), counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_grant_reg     <= 1'b0;
         wr_base_addr_reg <= '0;
         wr_idx_reg       <= 3'd0;
         rd_grant_reg     <= 1'b0;
         rd_base_addr_reg <= '0;
         rd_seq_reg       <= '0;
         rd_slot_reg      <= 3'd0;
         drop_cnt_reg     <= 16'd0;
         ready_cnt_reg    <= 4'd0;
      end else begin
         wr_grant_reg  <= wr_take;
         rd_grant_reg  <= rd_take;
         ready_cnt_reg <= ready_cnt_next;
         if (wr_take) begin
            wr_base_addr_reg <= slot_addr(wr_pick, frame_bytes);
            wr_idx_reg       <= wr_pick;
         end
         if (rd_take) begin
            rd_base_addr_reg <= slot_addr(rd_pick, frame_bytes);
            rd_seq_reg       <= rd_pick_tag;
            rd_slot_reg      <= rd_pick;
         end
         if (wr_drop && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
   end

   assign wr_grant     = wr_grant_reg;
   assign wr_base_addr = wr_base_addr_reg;
   assign wr_idx       = wr_idx_reg;
   assign rd_grant     = rd_grant_reg;
   assign rd_base_addr = rd_base_addr_reg;
   assign rd_seq       = rd_seq_reg;
   assign drop_cnt     = drop_cnt_reg;
   assign ready_cnt    = ready_cnt_reg;

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Manages NUM_BUFS frame buffers in external memory, shared between the frame writer (stream-to-AXI burst path) and a frame reader.
- Hands out buffer base addresses and tracks each slot as FREE, WRITING, READY or READING.
- Writer never overwrites the buffer being read; reader always gets the newest completed frame.
- Sits between the frame writer/reader sequencers and the AXI burst master command inputs.

Parameters:
- ADDR_WIDTH, 32, address width.
- NUM_BUFS, 3, number of frame slots; legal range 3..8.
- BASE_ADDR, 32'h0000_1000, address of slot 0.
- SEQ_WIDTH, 8, frame sequence tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_bytes  in  32  slot stride in bytes; static while any slot is not FREE.
- wr_req  in  1  writer requests a buffer; level, held until wr_grant.
- wr_grant  out  1  one-cycle pulse: wr_base_addr/wr_idx valid.
- wr_base_addr  out  ADDR_WIDTH  base of allocated write slot.
- wr_idx  out  3  allocated slot index.
- wr_done  in  1  pulse: frame fully written (frame_ready).
- rd_req  in  1  reader requests a frame; level, held until rd_grant.
- rd_grant  out  1  one-cycle pulse.
- rd_base_addr  out  ADDR_WIDTH  base of granted read slot.
- rd_seq  out  SEQ_WIDTH  sequence tag of granted frame.
- rd_done  in  1  pulse: reader finished with slot.
- drop_cnt  out  16  frames overwritten before being read; saturates at 16'hFFFF.
- ready_cnt  out  4  number of READY slots.

Behaviour:
- Reset: all slots FREE, tags 0, wr_seq=0; all outputs 0; both FSMs idle. Reset mid-operation discards all slot state with no completion.
- Per-slot state is 2 bits, plus a SEQ_WIDTH tag.
- wr_seq increments by 1 (wrapping) on each accepted wr_done. The completed slot gets tag=wr_seq (pre-increment) and becomes READY.
- Age of a READY slot = (wr_seq - tag) mod 2^SEQ_WIDTH. Oldest = largest age; newest = smallest age.
- Slot address = BASE_ADDR + idx*frame_bytes, truncated to ADDR_WIDTH. It is registered with the grant.
- Arbitration each cycle uses registered (pre-edge) slot states. All slot updates occur at that edge.

Writer FSM:
- W_IDLE: on wr_req, go to W_GRANT.
- W_GRANT: pick the lowest-index FREE slot. If none is FREE, pick the oldest READY slot, drop it, and increment drop_cnt.
- The chosen slot becomes WRITING. Pulse wr_grant, go to W_ACTIVE. Latency: wr_req rising -> wr_grant at the second clock edge.
- W_ACTIVE: wr_done -> slot becomes READY, go to W_IDLE. wr_req is ignored while in W_ACTIVE.
- wr_done outside W_ACTIVE is ignored.

Reader FSM:
- R_IDLE: on rd_req, go to R_WAIT.
- R_WAIT: if any slot is READY, the newest becomes READING. Other READY slots stay READY. Pulse rd_grant, go to R_ACTIVE. Otherwise stay in R_WAIT.
- R_ACTIVE: rd_done -> slot becomes FREE, go to R_IDLE.
- rd_done outside R_ACTIVE is ignored.

Simultaneous events:
- W_GRANT and R_WAIT in the same cycle: reader takes the newest READY first. The writer's oldest-READY fallback excludes that slot. NUM_BUFS>=3 guarantees a distinct slot.
- wr_done in the same cycle as R_WAIT with no READY slot: reader grants one cycle later, with the just-completed frame.
- wr_done and rd_done in the same cycle: both updates apply.
- At most one slot is WRITING and one READING at any time.

Other rules:
- ready_cnt is registered and reflects post-edge state.
- Granted addresses stay stable until the next grant.

Test Plan:
- Setup for all: NUM_BUFS=3, BASE_ADDR=0x1000, frame_bytes=32.
- Reset then wr_req -> wr_grant 2 cycles later, wr_idx=0, wr_base_addr=0x1000. Then wr_done -> ready_cnt=1.
- Three write cycles with no reader -> slots 0,1,2 READY, tags 0,1,2. Fourth wr_req -> wr_idx=0 (oldest dropped), drop_cnt=1.
- Frames 0,1 READY, then rd_req -> rd_grant, rd_base_addr=0x1020, rd_seq=1. Next wr_req -> wr_idx=2 (FREE slot preferred over READY slot 0).
- rd_req with nothing READY -> no grant for 10 cycles. Complete a write to slot 0 -> rd_grant on the following cycle, rd_base_addr=0x1000.
- Reader holds slot 1 READING, slots 0 and 2 READY. Repeated writes -> writer alternates slots 0/2 and never returns wr_idx=1. drop_cnt increments per overwrite.
- Assert rst_n=0 mid-W_ACTIVE -> all outputs 0 immediately. After release, wr_req is granted slot 0 and drop_cnt=0.
